arb_prio_16: RTL and testbench

ARB_PRIO_16 -- requirements
Module: arb_prio_16

---
 rtl/arb_prio_16.sv | 138 +++++++++++++
 tb/tb_arb_prio_16.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arb_prio_16.sv
// 16-way non-preemptive arbiter with one-cycle gap between grants and a MAX_HOLD forced release.
// Optional round-robin ranking is enabled by defining ARB_ROUND_ROBIN_EN (fixed priority otherwise).
module arb_prio_16 #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_vld,
    output logic        timeout
);

    localparam int unsigned N   = 16;
    localparam int unsigned IDW = 4;
    localparam int unsigned CW  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     gnt_nxt;
    logic [IDW-1:0]   gnt_id_nxt;
    logic             gnt_vld_nxt;
    logic             timeout_nxt;
    logic [CW-1:0]    hold_cnt, hold_cnt_nxt;
    logic [IDW-1:0]   win_id;
    logic             win_vld;
    logic             hold_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]   last_id, last_id_nxt;

    // Scan lowest to highest priority so the highest-ranked requester is written last.
    always_comb begin
        win_id = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[IDW'(last_id - IDW'(k))]) begin
                win_id = IDW'(last_id - IDW'(k));
            end
        end
    end
`else
    // Fixed priority: highest set index wins.
    always_comb begin
        win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                win_id = IDW'(i);
            end
        end
    end
`endif

    assign win_vld  = |req;
    assign hold_hit = (hold_cnt == CW'(MAX_HOLD - 1));

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        gnt_vld_nxt  = gnt_vld;
        timeout_nxt  = 1'b0;
        hold_cnt_nxt = hold_cnt;
`ifdef ARB_ROUND_ROBIN_EN
        last_id_nxt  = last_id;
`endif
        case (state)
            IDLE, GAP: begin
                gnt_nxt     = '0;
                gnt_id_nxt  = '0;
                gnt_vld_nxt = 1'b0;
                state_nxt   = IDLE;
                if (win_vld) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = N'(1) << win_id;
                    gnt_id_nxt   = win_id;
                    gnt_vld_nxt  = 1'b1;
                    hold_cnt_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_id_nxt  = win_id;
`endif
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + CW'(1);
                // Timeout flags only a release caused by the hold limit alone.
                if (done || !req[gnt_id] || hold_hit) begin
                    state_nxt   = GAP;
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '0;
                    gnt_vld_nxt = 1'b0;
                    timeout_nxt = hold_hit && !done && req[gnt_id];
                end
            end
            default: begin
                state_nxt   = IDLE;
                gnt_nxt     = '0;
                gnt_id_nxt  = '0;
                gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            gnt_vld  <= gnt_vld_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= '0;
        end else begin
            last_id <= last_id_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_arb_prio_16.sv
// Scoreboard bench for arb_prio_16: a cycle-level reference model pushes expected outputs,
// an independent monitor pops and compares them one time unit after each rising edge.
module tb_arb_prio_16;

    localparam int unsigned MAX_HOLD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_vld;
    logic        timeout;

    int checks;
    int failures;

    // Expected payload: {gnt[15:0], gnt_id[3:0], gnt_vld, timeout}
    logic [21:0] exp_q[$];

    arb_prio_16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner choice expressed as a priority list walk.
    function automatic int pick(logic [15:0] r, int lst);
        int  res;
        bit  found;
        res   = -1;
        found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (lst - k + 32) % 16;
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
`else
        for (int i = 15; i >= 0; i--) begin
            if (!found && r[i]) begin
                res   = i;
                found = 1'b1;
            end
        end
`endif
        return res;
    endfunction

    // Reference model: owner is the current grantee (-1 when nobody holds the resource).
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;

    always @(posedge clk) begin
        logic [15:0] eg;
        logic        eto;
        eto = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 0;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            if (done || !req[m_owner] || m_held >= int'(MAX_HOLD)) begin
                eto     = (m_held >= int'(MAX_HOLD)) && !done && req[m_owner];
                m_owner = -1;
            end
        end else if (req != 16'h0000) begin
            m_owner = pick(req, m_last);
            m_last  = m_owner;
            m_held  = 0;
        end
        eg = 16'h0000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        exp_q.push_back({eg, (m_owner >= 0) ? 4'(m_owner) : 4'd0, m_owner >= 0, eto});
    end

    // Monitor: compares DUT outputs against the oldest expectation each cycle.
    always @(posedge clk) begin
        logic [21:0] e;
        #1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({gnt, gnt_id, gnt_vld, timeout} !== e) begin
                failures = failures + 1;
                $display("FAIL cycle_out t=%0t req=%h actual gnt=%h id=%0d vld=%b to=%b required gnt=%h id=%0d vld=%b to=%b",
                         $time, req, gnt, gnt_id, gnt_vld, timeout, e[21:6], e[5:2], e[1], e[0]);
            end
        end
    end

    task automatic drive(input logic [15:0] r, input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req  = r;
            done = d;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        req  = 16'h0000;
        done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        drive(16'h0000, 1'b0, 3);
        // Request-to-grant latency and done-driven release/regrant
        drive(16'h0081, 1'b0, 3);
        drive(16'h0081, 1'b1, 1);
        drive(16'h0081, 1'b0, 5);
        drive(16'h0000, 1'b0, 3);
        // Forced release by hold limit
        drive(16'h8000, 1'b0, 14);
        // done coincident with the hold-limit edge
        drive(16'h0000, 1'b0, 2);
        drive(16'h8000, 1'b0, 4);
        drive(16'h8000, 1'b1, 1);
        drive(16'h8000, 1'b0, 2);
        // Request drop returns to idle
        drive(16'h0000, 1'b0, 2);
        drive(16'h0004, 1'b0, 3);
        drive(16'h0000, 1'b0, 3);
        // All requesting, done every cycle
        drive(16'hFFFF, 1'b1, 12);
        drive(16'h0000, 1'b0, 2);

        // Asynchronous reset between edges while a grant is held
        drive(16'h0002, 1'b0, 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || timeout !== 1'b0 || gnt_id !== 4'd0) begin
            failures = failures + 1;
            $display("FAIL async_reset actual gnt=%h id=%0d vld=%b to=%b required all zero",
                     gnt, gnt_id, gnt_vld, timeout);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h0002, 1'b0, 3);

        // Randomized traffic: sticky requests with occasional changes and done pulses
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(3, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: req = 16'h0000;
                    1: req = 16'(1) << $urandom_range(15, 0);
                    2: req = 16'($urandom) & 16'($urandom);
                    default: req = 16'($urandom);
                endcase
            end
            done = ($urandom_range(4, 0) == 0);
            if ($urandom_range(199, 0) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        drive(16'h0000, 1'b0, 3);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
